i2c_slave: RTL



---
 rtl/i2c_slave.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target endpoint backed by a small byte-wide register file
//
// Purpose:
//   Answers I2C transfers of the form
//     START, {dev_addr, r/w}, ACK, mem_addr, ACK, data, ACK, ..., STOP
//   and stores/returns bytes in a 2**MEM_AW deep register file. SCL and SDA
//   are oversampled on clk; SDA is driven open-drain through SDA_low.
//
// Ports:
//   clk       system clock, at least 8x the SCL frequency
//   reset     synchronous, active-high
//   SCL       I2C clock from the master
//   SDA_i     sampled SDA line level (includes our own pull-down)
//   SDA_low   1 = pull SDA low, 0 = release
//   busy      high from a matching device address until STOP/IDLE
//   wr_valid  one-cycle pulse when a write byte is committed
//   wr_addr   address of the committed byte
//   wr_data   committed byte
//   nack_err  one-cycle pulse when the target drops out of a transfer

module i2c_slave #(
    parameter logic [6:0] DEVICE_ADDR = 7'b0000001,
    parameter int         MEM_AW      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCL,
    input  logic              SDA_i,
    output logic              SDA_low,
    output logic              busy,
    output logic              wr_valid,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              nack_err
);

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        MEM_ADDR,
        MEM_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    localparam logic [MEM_AW-1:0] PTR_ONE = 1;

    // Input conditioning: two synchronizer flops plus one history flop each.
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle bus level, so leaving reset never fakes an edge.
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA_i};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    logic scl_now;
    logic sda_now;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_now   = scl_sync[1];
    assign sda_now   = sda_sync[1];
    assign scl_rise  = scl_now & ~scl_hist;
    assign scl_fall  = ~scl_now & scl_hist;
    // SDA edges only count as START/STOP while SCL is steadily high.
    assign start_det = scl_now & scl_hist & sda_hist & ~sda_now;
    assign stop_det  = scl_now & scl_hist & ~sda_hist & sda_now;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [6:0]        shift;
    logic [MEM_AW-1:0] ptr;
    logic              rw;
    logic              got_ack;

    // Byte completed by the bit being sampled this cycle.
    logic [7:0] rx_byte;
    logic       last_bit;

    assign rx_byte  = {shift, sda_now};
    assign last_bit = (bit_cnt == 3'd7);

    // Register file: not cleared by reset, read combinationally.
    logic [7:0] mem [2**MEM_AW];
    logic       mem_we;
    logic [7:0] rd_byte;

    assign mem_we  = ~reset & (state == WR_DATA) & scl_rise & last_bit
                   & ~start_det & ~stop_det;
    assign rd_byte = mem[ptr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            ptr      <= '0;
            rw       <= 1'b0;
            got_ack  <= 1'b0;
            SDA_low  <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            nack_err <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            nack_err <= 1'b0;

            if (stop_det) begin
                state   <= IDLE;
                SDA_low <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                // Repeated START from any state restarts address decode.
                // SDA is released defensively; a legal START never finds it held.
                state   <= DEV_ADDR;
                bit_cnt <= 3'd0;
                SDA_low <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= 3'd0;
                    end

                    DEV_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (rx_byte[7:1] == DEVICE_ADDR) begin
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                    state <= DEV_ACK;
                                end else begin
                                    nack_err <= 1'b1;
                                    state    <= WAIT_STOP;
                                end
                            end
                        end
                    end

                    // ACK slots: first fall pulls SDA low, second fall ends the slot.
                    DEV_ACK: begin
                        if (scl_fall) begin
                            if (!SDA_low) begin
                                SDA_low <= 1'b1;
                            end else begin
                                SDA_low <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= MEM_ADDR;
                            end
                        end
                    end

                    MEM_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                ptr   <= rx_byte[MEM_AW-1:0];
                                state <= MEM_ACK;
                            end
                        end
                    end

                    MEM_ACK: begin
                        if (scl_fall) begin
                            if (!SDA_low) begin
                                SDA_low <= 1'b1;
                            end else if (rw) begin
                                // Read: bit 7 goes out on the fall that ends the ACK.
                                shift   <= rd_byte[6:0];
                                SDA_low <= ~rd_byte[7];
                                bit_cnt <= 3'd0;
                                state   <= RD_DATA;
                            end else begin
                                SDA_low <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= WR_DATA;
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                wr_valid <= 1'b1;
                                wr_addr  <= ptr;
                                wr_data  <= rx_byte;
                                state    <= WR_ACK;
                            end
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!SDA_low) begin
                                SDA_low <= 1'b1;
                            end else begin
                                SDA_low <= 1'b0;
                                ptr     <= ptr + PTR_ONE;
                                bit_cnt <= 3'd0;
                                state   <= WR_DATA;
                            end
                        end
                    end

                    // bit_cnt counts falls here; bits 6..0 go out on falls 1..7,
                    // and the 8th fall hands SDA back for the master's ACK.
                    RD_DATA: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                SDA_low <= 1'b0;
                                got_ack <= 1'b0;
                                state   <= RD_ACK;
                            end else begin
                                SDA_low <= ~shift[6];
                                shift   <= {shift[5:0], 1'b0};
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            // Anything other than a clean 0 (including X) is a NACK.
                            if (sda_now == 1'b0) begin
                                ptr     <= ptr + PTR_ONE;
                                got_ack <= 1'b1;
                            end else begin
                                nack_err <= 1'b1;
                                state    <= WAIT_STOP;
                            end
                        end else if (scl_fall && got_ack) begin
                            shift   <= rd_byte[6:0];
                            SDA_low <= ~rd_byte[7];
                            bit_cnt <= 3'd0;
                            got_ack <= 1'b0;
                            state   <= RD_DATA;
                        end
                    end

                    WAIT_STOP: begin
                        SDA_low <= 1'b0;
                    end

                    default: begin
                        state   <= IDLE;
                        SDA_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
